ro_puf_seq_ctrl: RTL and testbench

Parametrised sequencer for the ring-oscillator PUF. It generalises the fixed 128-bit enable controller with a start/done handshake, a configurable signature length and a settle gap between evaluations. It also adds RO-pair selection, per-evaluation timeout with a sticky error flag, abort, and an on-chip signature register. It sits between the host/test logic and the RO counter/comparator block, and drives `roen`, `pair_sel` and `ctr_clr` to that block.

---
 rtl/ro_puf_seq_ctrl_if.sv | 29 ++
 rtl/ro_puf_seq_ctrl.sv | 139 +++++++++++++
 tb/tb_ro_puf_seq_ctrl.sv | 251 +++++++++++++++++++++++++
 3 files changed

// File: rtl/ro_puf_seq_ctrl_if.sv
// Handshake bundle between host/test logic, the PUF sequencer and the RO counter block.
// The sequencer takes the slave side; the host/counter model takes the master side.
interface ro_puf_seq_ctrl_if #(
    parameter int SIG_BITS = 128
);
    localparam int IDX_W = $clog2(SIG_BITS);

    logic                start;
    logic                abort;
    logic [1:0]          counter_ctrl_state;
    logic                cmp_bit;
    logic                roen;
    logic                ctr_clr;
    logic [IDX_W-1:0]    pair_sel;
    logic                busy;
    logic                done;
    logic                err;
    logic [SIG_BITS-1:0] sig;

    modport master (
        output start, abort, counter_ctrl_state, cmp_bit,
        input  roen, ctr_clr, pair_sel, busy, done, err, sig
    );

    modport slave (
        input  start, abort, counter_ctrl_state, cmp_bit,
        output roen, ctr_clr, pair_sel, busy, done, err, sig
    );
endinterface

// File: rtl/ro_puf_seq_ctrl.sv
// Ring-oscillator PUF sequencer: walks SIG_BITS RO pairs through settle/evaluate phases,
// collects comparator bits into a signature register, with timeout, abort and done pulse.
module ro_puf_seq_ctrl #(
    parameter int SIG_BITS      = 128,
    parameter int SETTLE_CYCLES = 4,
    parameter int TIMEOUT       = 1024
) (
    input  logic               clk,
    input  logic               rst,
    ro_puf_seq_ctrl_if.slave   bus
);
    localparam int IDX_W = $clog2(SIG_BITS);
    localparam int TMO_W = $clog2(TIMEOUT);
    localparam int STL_W = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;

    localparam logic [IDX_W-1:0] LAST_IDX   = IDX_W'(SIG_BITS - 1);
    localparam logic [TMO_W-1:0] TMO_LAST   = TMO_W'(TIMEOUT - 1);
    localparam logic [STL_W-1:0] SETTLE_END = STL_W'(SETTLE_CYCLES - 1);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_SETTLE = 2'd1,
        S_EVAL   = 2'd2,
        S_DONE   = 2'd3
    } state_t;

    state_t              r_state;
    logic [STL_W-1:0]    r_settle_tmr;
    logic [TMO_W-1:0]    r_eval_tmr;
    logic [IDX_W-1:0]    r_pair_sel;
    logic [SIG_BITS-1:0] r_sig;
    logic                r_roen;
    logic                r_ctr_clr;
    logic                r_busy;
    logic                r_done;
    logic                r_err;

    logic w_cmp_done;
    logic w_timeout;
    logic w_last_pair;

    assign w_cmp_done  = (bus.counter_ctrl_state == 2'b11);
    assign w_timeout   = (r_eval_tmr == TMO_LAST);
    assign w_last_pair = (r_pair_sel == LAST_IDX);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state      <= S_IDLE;
            r_settle_tmr <= '0;
            r_eval_tmr   <= '0;
            r_pair_sel   <= '0;
            r_sig        <= '0;
            r_roen       <= 1'b0;
            r_ctr_clr    <= 1'b0;
            r_busy       <= 1'b0;
            r_done       <= 1'b0;
            r_err        <= 1'b0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (bus.start) begin
                        r_state      <= S_SETTLE;
                        r_sig        <= '0;
                        r_err        <= 1'b0;
                        r_pair_sel   <= '0;
                        r_settle_tmr <= '0;
                        r_busy       <= 1'b1;
                        r_ctr_clr    <= 1'b1;
                        r_roen       <= 1'b0;
                    end
                end

                S_SETTLE: begin
                    if (bus.abort) begin
                        r_state   <= S_IDLE;
                        r_busy    <= 1'b0;
                        r_roen    <= 1'b0;
                        r_ctr_clr <= 1'b0;
                    end else if (r_settle_tmr == SETTLE_END) begin
                        r_state    <= S_EVAL;
                        r_eval_tmr <= '0;
                        r_roen     <= 1'b1;
                        r_ctr_clr  <= 1'b0;
                    end else begin
                        r_settle_tmr <= r_settle_tmr + 1'b1;
                    end
                end

                S_EVAL: begin
                    if (bus.abort) begin
                        r_state   <= S_IDLE;
                        r_busy    <= 1'b0;
                        r_roen    <= 1'b0;
                        r_ctr_clr <= 1'b0;
                    end else if (w_cmp_done || w_timeout) begin
                        // A completion arriving on the timeout cycle still counts as a real result
                        r_sig[r_pair_sel] <= w_cmp_done ? bus.cmp_bit : 1'b0;
                        if (!w_cmp_done) begin
                            r_err <= 1'b1;
                        end
                        r_roen <= 1'b0;
                        if (w_last_pair) begin
                            r_state <= S_DONE;
                            r_done  <= 1'b1;
                            r_busy  <= 1'b0;
                        end else begin
                            r_state      <= S_SETTLE;
                            r_pair_sel   <= r_pair_sel + 1'b1;
                            r_settle_tmr <= '0;
                            r_ctr_clr    <= 1'b1;
                        end
                    end else begin
                        r_eval_tmr <= r_eval_tmr + 1'b1;
                    end
                end

                S_DONE: begin
                    r_state <= S_IDLE;
                end

                default: begin
                    r_state   <= S_IDLE;
                    r_busy    <= 1'b0;
                    r_roen    <= 1'b0;
                    r_ctr_clr <= 1'b0;
                end
            endcase
        end
    end

    assign bus.roen     = r_roen;
    assign bus.ctr_clr  = r_ctr_clr;
    assign bus.pair_sel = r_pair_sel;
    assign bus.busy     = r_busy;
    assign bus.done     = r_done;
    assign bus.err      = r_err;
    assign bus.sig      = r_sig;
endmodule

// File: tb/tb_ro_puf_seq_ctrl.sv
// Bench for ro_puf_seq_ctrl: table of acquisitions scored through a done-triggered queue,
// plus hand sequences for abort, ignored start, reset and out-of-EVAL completions.
module tb_ro_puf_seq_ctrl;
    localparam int SB = 8;
    localparam int ST = 4;
    localparam int TO = 16;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    ro_puf_seq_ctrl_if #(.SIG_BITS(SB)) bus ();

    ro_puf_seq_ctrl #(
        .SIG_BITS     (SB),
        .SETTLE_CYCLES(ST),
        .TIMEOUT      (TO)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    typedef struct {
        logic [7:0]      bits;
        logic [7:0][4:0] k;
        logic [7:0]      sig;
        logic            err;
        int              lat;
    } vec_t;

    typedef struct {
        logic [7:0] sig;
        logic       err;
        int         lat;
        int         t0;
    } exp_t;

    int   total = 0;
    int   fail  = 0;
    int   cyc   = 0;
    exp_t sb[$];
    exp_t mon_e;
    vec_t vecs[6];

    logic [7:0]      cfg_bits = '0;
    logic [7:0][4:0] cfg_k    = '0;
    bit              force11  = 1'b0;
    int              ev_cnt   = 0;
    bit              prev_done = 1'b0;
    bit              mon_en    = 1'b0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            fail++;
            $display("FAIL %s: got 0x%0h, want 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Counter-block model: completes on the k-th cycle with roen high (k=0 never completes)
    always @(negedge clk) begin
        if (force11) begin
            bus.counter_ctrl_state = 2'b11;
            bus.cmp_bit            = 1'b1;
        end else if (bus.roen) begin
            ev_cnt = ev_cnt + 1;
            if (ev_cnt == int'(cfg_k[bus.pair_sel])) begin
                bus.counter_ctrl_state = 2'b11;
                bus.cmp_bit            = cfg_bits[bus.pair_sel];
            end else begin
                bus.counter_ctrl_state = 2'($urandom_range(0, 2));
                bus.cmp_bit            = 1'($urandom);
            end
        end else begin
            ev_cnt                 = 0;
            bus.counter_ctrl_state = 2'($urandom_range(0, 3));
            bus.cmp_bit            = 1'($urandom);
        end
    end

    always @(negedge clk) begin
        if (mon_en) begin
            chk("roen_only_in_eval", {31'b0, bus.roen & (bus.ctr_clr | ~bus.busy)}, 32'd0);
            if (bus.done) begin
                chk("done_width", {31'b0, prev_done}, 32'd0);
                chk("done_busy", {31'b0, bus.busy}, 32'd0);
                if (sb.size() == 0) begin
                    total++;
                    fail++;
                    $display("FAIL unexpected_done: done with no acquisition pending (cycle %0d)", cyc);
                end else begin
                    mon_e = sb.pop_front();
                    chk("sb_sig", {24'b0, bus.sig}, {24'b0, mon_e.sig});
                    chk("sb_err", {31'b0, bus.err}, {31'b0, mon_e.err});
                    chk("sb_latency", cyc - mon_e.t0, mon_e.lat);
                end
            end
            prev_done = bus.done;
        end
    end

    task automatic launch(input logic [7:0] bits, input logic [7:0][4:0] k, input bit push,
                          input logic [7:0] esig, input logic eerr, input int elat);
        exp_t e;
        cfg_bits = bits;
        cfg_k    = k;
        @(negedge clk);
        if (push) begin
            e.sig = esig;
            e.err = eerr;
            e.lat = elat;
            e.t0  = cyc;
            sb.push_back(e);
        end
        bus.start = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
    endtask

    task automatic wait_drain(input int budget);
        for (int i = 0; i < budget && sb.size() != 0; i++) @(negedge clk);
        chk("drain_pending", sb.size(), 32'd0);
        sb.delete();
    endtask

    task automatic wait_eval(input int p, input int budget);
        for (int i = 0; i < budget && !(bus.roen && bus.pair_sel == 3'(p)); i++) @(negedge clk);
        chk("reach_eval", {31'b0, bus.roen && bus.pair_sel == 3'(p)}, 32'd1);
    endtask

    initial begin
        bus.start = 1'b0;
        bus.abort = 1'b0;

        vecs[0] = '{bits: 8'hAA, k: {8{5'd3}}, sig: 8'hAA, err: 1'b0, lat: 57};
        vecs[1] = '{bits: 8'hAA, k: {5'd3, 5'd3, 5'd0, 5'd3, 5'd3, 5'd3, 5'd3, 5'd3},
                    sig: 8'h8A, err: 1'b1, lat: 70};
        vecs[2] = '{bits: 8'hAA, k: {5'd16, {7{5'd3}}}, sig: 8'hAA, err: 1'b0, lat: 70};
        vecs[3] = '{bits: 8'h5C, k: {5'd8, 5'd7, 5'd6, 5'd5, 5'd4, 5'd3, 5'd2, 5'd1},
                    sig: 8'h5C, err: 1'b0, lat: 69};
        vecs[4] = '{bits: 8'hFF, k: {8{5'd1}}, sig: 8'hFF, err: 1'b0, lat: 41};
        vecs[5] = '{bits: 8'hFF, k: {5'd0, {6{5'd2}}, 5'd0}, sig: 8'h7E, err: 1'b1, lat: 77};

        repeat (3) @(negedge clk);
        chk("rst_roen", {31'b0, bus.roen}, 32'd0);
        chk("rst_ctr_clr", {31'b0, bus.ctr_clr}, 32'd0);
        chk("rst_pair_sel", {29'b0, bus.pair_sel}, 32'd0);
        chk("rst_busy", {31'b0, bus.busy}, 32'd0);
        chk("rst_done", {31'b0, bus.done}, 32'd0);
        chk("rst_err", {31'b0, bus.err}, 32'd0);
        chk("rst_sig", {24'b0, bus.sig}, 32'd0);
        rst = 1'b0;
        mon_en = 1'b1;
        repeat (2) @(negedge clk);

        for (int v = 0; v < 6; v++) begin
            launch(vecs[v].bits, vecs[v].k, 1'b1, vecs[v].sig, vecs[v].err, vecs[v].lat);
            wait_drain(300);
            repeat (2) @(negedge clk);
            chk("idle_busy", {31'b0, bus.busy}, 32'd0);
            chk("idle_sig_hold", {24'b0, bus.sig}, {24'b0, vecs[v].sig});
            chk("idle_err_hold", {31'b0, bus.err}, {31'b0, vecs[v].err});
            chk("idle_pair_hold", {29'b0, bus.pair_sel}, 32'd7);
        end

        // Abort during EVAL of pair 3, then a clean restart
        launch(8'hAA, {8{5'd3}}, 1'b0, 8'h00, 1'b0, 0);
        wait_eval(3, 200);
        bus.abort = 1'b1;
        @(negedge clk);
        bus.abort = 1'b0;
        chk("abort_busy", {31'b0, bus.busy}, 32'd0);
        chk("abort_roen", {31'b0, bus.roen}, 32'd0);
        chk("abort_ctr_clr", {31'b0, bus.ctr_clr}, 32'd0);
        chk("abort_done", {31'b0, bus.done}, 32'd0);
        chk("abort_sig", {24'b0, bus.sig}, 32'h02);
        chk("abort_err", {31'b0, bus.err}, 32'd0);
        repeat (12) @(negedge clk);
        chk("abort_stays_idle", {31'b0, bus.busy}, 32'd0);
        launch(8'hAA, {8{5'd3}}, 1'b1, 8'hAA, 1'b0, 57);
        chk("restart_sig_clr", {24'b0, bus.sig}, 32'd0);
        chk("restart_pair0", {29'b0, bus.pair_sel}, 32'd0);
        chk("restart_busy", {31'b0, bus.busy}, 32'd1);
        chk("restart_ctr_clr", {31'b0, bus.ctr_clr}, 32'd1);
        chk("restart_roen_c1", {31'b0, bus.roen}, 32'd0);
        repeat (3) @(negedge clk);
        chk("settle_roen_c4", {31'b0, bus.roen}, 32'd0);
        chk("settle_clr_c4", {31'b0, bus.ctr_clr}, 32'd1);
        @(negedge clk);
        chk("eval_roen_c5", {31'b0, bus.roen}, 32'd1);
        chk("eval_clr_c5", {31'b0, bus.ctr_clr}, 32'd0);
        wait_drain(300);

        // start pulses while busy and during DONE must be ignored
        launch(8'hFF, {8{5'd1}}, 1'b1, 8'hFF, 1'b0, 41);
        repeat (7) @(negedge clk);
        bus.start = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
        repeat (10) @(negedge clk);
        bus.start = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
        for (int i = 0; i < 100 && !bus.done; i++) @(negedge clk);
        chk("done_seen", {31'b0, bus.done}, 32'd1);
        bus.start = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
        chk("start_in_done_busy", {31'b0, bus.busy}, 32'd0);
        chk("start_in_done_clr", {31'b0, bus.ctr_clr}, 32'd0);
        chk("start_in_done_done", {31'b0, bus.done}, 32'd0);
        repeat (20) @(negedge clk);
        chk("no_restart_busy", {31'b0, bus.busy}, 32'd0);
        chk("single_done", sb.size(), 32'd0);

        // Reset in the middle of EVAL
        launch(8'hAA, {8{5'd3}}, 1'b0, 8'h00, 1'b0, 0);
        wait_eval(2, 200);
        rst = 1'b1;
        @(negedge clk);
        chk("mrst_roen", {31'b0, bus.roen}, 32'd0);
        chk("mrst_ctr_clr", {31'b0, bus.ctr_clr}, 32'd0);
        chk("mrst_pair_sel", {29'b0, bus.pair_sel}, 32'd0);
        chk("mrst_busy", {31'b0, bus.busy}, 32'd0);
        chk("mrst_done", {31'b0, bus.done}, 32'd0);
        chk("mrst_err", {31'b0, bus.err}, 32'd0);
        chk("mrst_sig", {24'b0, bus.sig}, 32'd0);
        rst = 1'b0;

        // Completion reported in IDLE and SETTLE must not touch sig
        force11 = 1'b1;
        repeat (4) @(negedge clk);
        chk("idle_cmp_sig", {24'b0, bus.sig}, 32'd0);
        chk("idle_cmp_busy", {31'b0, bus.busy}, 32'd0);
        launch(8'hFF, {8{5'd1}}, 1'b1, 8'hFF, 1'b0, 41);
        chk("settle_cmp_sig_c1", {24'b0, bus.sig}, 32'd0);
        for (int i = 2; i <= ST; i++) begin
            @(negedge clk);
            chk("settle_cmp_sig", {24'b0, bus.sig}, 32'd0);
        end
        wait_drain(300);
        force11 = 1'b0;
        repeat (3) @(negedge clk);

        $display("%0d/%0d checks passed", total - fail, total);
        $finish;
    end
endmodule
